// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 2-FF input synchronizer, one-entry read-to-clear byte register.
// Latency: stop bit sampled CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after IDLE sees the start edge; rx_valid set on that edge.
// Backpressure: none on the line side; an unread byte is overwritten and flagged by the sticky overrun bit.
//
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit, PARITY_ODD parameter, parity_err output).
// Ports:
//   clk_50M    in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   uart_rxd   in   asynchronous serial line, idle high
//   rx_read    in   one-cycle pulse, consumes rx_data and clears the status flags
//   rx_data    out  last good byte (LSB received first)
//   rx_valid   out  a byte is waiting to be read
//   overrun    out  sticky, an unread byte was overwritten
//   frame_err  out  sticky, a stop bit was sampled low
//   busy       out  FSM is not in IDLE
//   parity_err out  (parity build only) sticky, parity mismatch on a delivered byte
module uart_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       uart_rxd,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY
`endif
    } state_t;

    state_t           r_state;
    logic             r_rxd_meta;
    logic             r_rxd_s;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             r_frame_err;
    logic             r_busy;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bad;
    logic             r_parity_err;
`endif

    logic w_tick;
    logic w_stop_good;
    logic w_stop_bad;

    assign w_tick      = (r_cnt == '0);
    assign w_stop_good = (r_state == S_STOP) && w_tick && r_rxd_s;
    assign w_stop_bad  = (r_state == S_STOP) && w_tick && !r_rxd_s;

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            // Synchronizer resets to the idle line level so reset release never looks like a start bit.
            r_rxd_meta   <= 1'b1;
            r_rxd_s      <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_s    <= r_rxd_meta;

            // Status: the read clear comes first so that a same-cycle set below wins.
            if (rx_read) begin
                r_valid      <= 1'b0;
                r_overrun    <= 1'b0;
                r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_parity_err <= 1'b0;
`endif
            end
            if (w_stop_good) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                // A read in the same cycle consumes the old byte, so nothing is lost.
                if (r_valid && !rx_read) begin
                    r_overrun <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                if (r_par_bad) begin
                    r_parity_err <= 1'b1;
                end
`endif
            end
            if (w_stop_bad) begin
                r_frame_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_rxd_s) begin
                        r_state <= S_START;
                        r_cnt   <= CNT_HALF;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        // Re-check at mid start bit; a high line means the edge was a glitch.
                        if (!r_rxd_s) begin
                            r_state <= S_DATA;
                            r_cnt   <= CNT_FULL;
                            r_idx   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_rxd_s, r_shift[7:1]};
                        r_cnt   <= CNT_FULL;
                        if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        // XOR of data and parity bit equals PARITY_ODD on a correct frame.
                        r_par_bad <= (^r_shift) ^ r_rxd_s ^ PARITY_ODD;
                        r_cnt     <= CNT_FULL;
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        if (r_rxd_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_BREAK: begin
                    // Hold off until the line returns high so a held-low line does not retrigger.
                    if (r_rxd_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 16 clocks per bit.
// Latency: frames are driven bit-exact so the stop-sample cycle can be checked directly.
// Backpressure: rx_read is pulsed by the bench, including on the stop-sample cycle.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_CYC = 171;
`else
    localparam int STOP_CYC = 155;
`endif

    logic       clk_50M  = 1'b0;
    logic       reset    = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       rx_read  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk_50M = ~clk_50M;

    uart_rx #(
        .CLK_FREQ (50000000),
        .BAUD     (3125000)
    ) dut (
        .clk_50M   (clk_50M),
        .reset     (reset),
        .uart_rxd  (uart_rxd),
        .rx_read   (rx_read),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .overrun   (overrun),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    // Start bit is driven 1 time unit after the first posedge (P0); line left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        logic [10:0] bits;
        logic        p;
        int          nb;
        p = (^b) ^ par_flip;
`ifdef UART_RX_PARITY_EN
        bits = {stop_bit, p, b, 1'b0};
        nb   = 11;
`else
        bits = {p, stop_bit, b, 1'b0};
        nb   = 10;
`endif
        @(posedge clk_50M); #1;
        for (int i = 0; i < nb; i++) begin
            uart_rxd = bits[i];
            repeat (CPB) @(posedge clk_50M);
            #1;
        end
    endtask

    task automatic pulse_read();
        @(posedge clk_50M); #1 rx_read = 1'b1;
        @(posedge clk_50M); #1 rx_read = 1'b0;
    endtask

    task automatic test_reset();
        logic bad;
        bad = 1'b0;
        repeat (3) @(posedge clk_50M);
        #1;
        if ({rx_data, rx_valid, overrun, frame_err, busy} !== 12'h000) begin
            $display("FAIL reset_state: got %h want 000", {rx_data, rx_valid, overrun, frame_err, busy});
            n_fail++;
        end
        n_tests++;
        reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_50M); #1;
            if ({rx_data, rx_valid, overrun, frame_err, busy} !== 12'h000) bad = 1'b1;
        end
        if (bad !== 1'b0) begin
            $display("FAIL idle_line: outputs moved, got flag %b want 0", bad);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_latency();
        int rise;
        rise = -1;
        fork
            send_frame(8'h96, 1'b1, 1'b0);
            begin
                @(posedge clk_50M);
                for (int c = 1; c <= STOP_CYC + 20; c++) begin
                    @(posedge clk_50M); #1;
                    if (c == 2 && busy !== 1'b0) begin
                        $display("FAIL busy_early: got %b want 0", busy);
                        n_fail++;
                    end
                    if (c == 2) n_tests++;
                    if (c == 3 && busy !== 1'b1) begin
                        $display("FAIL busy_rise: got %b want 1", busy);
                        n_fail++;
                    end
                    if (c == 3) n_tests++;
                    if (rx_valid && rise < 0) rise = c;
                end
            end
        join
        if (rise != STOP_CYC) begin
            $display("FAIL latency: rx_valid rose at cycle %0d want %0d", rise, STOP_CYC);
            n_fail++;
        end
        n_tests++;
        if (rx_data !== 8'h96) begin
            $display("FAIL latency_data: got %h want 96", rx_data);
            n_fail++;
        end
        n_tests++;
        pulse_read();
    endtask

    task automatic test_basic();
        logic [7:0] v [3];
        v = '{8'h21, 8'h43, 8'h65};
        for (int i = 0; i < 3; i++) begin
            send_frame(v[i], 1'b1, 1'b0);
            if ({rx_data, rx_valid, overrun, frame_err} !== {v[i], 3'b100}) begin
                $display("FAIL basic_rx%0d: got %h/%b%b%b want %h/100", i, rx_data, rx_valid,
                         overrun, frame_err, v[i]);
                n_fail++;
            end
            n_tests++;
            pulse_read();
            if (rx_valid !== 1'b0 || rx_data !== v[i]) begin
                $display("FAIL basic_read%0d: got valid %b data %h want 0 %h", i, rx_valid, rx_data, v[i]);
                n_fail++;
            end
            n_tests++;
        end
    endtask

    task automatic test_glitch();
        @(posedge clk_50M); #1 uart_rxd = 1'b0;
        repeat (3) @(posedge clk_50M);
        #1 uart_rxd = 1'b1;
        if (busy !== 1'b1) begin
            $display("FAIL glitch_busy: got %b want 1", busy);
            n_fail++;
        end
        n_tests++;
        repeat (20) @(posedge clk_50M);
        #1;
        if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            $display("FAIL glitch_reject: got busy %b valid %b want 0 0", busy, rx_valid);
            n_fail++;
        end
        n_tests++;
        send_frame(8'hA5, 1'b1, 1'b0);
        if (rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
            $display("FAIL glitch_next: got %h/%b want a5/1", rx_data, rx_valid);
            n_fail++;
        end
        n_tests++;
        pulse_read();
    endtask

    task automatic test_framing();
        // rx_read lands on the stop-sample edge: the frame_err set must win over the clear.
        fork
            send_frame(8'h5A, 1'b0, 1'b0);
            begin
                @(posedge clk_50M);
                repeat (STOP_CYC - 1) @(posedge clk_50M);
                #1 rx_read = 1'b1;
                @(posedge clk_50M); #1 rx_read = 1'b0;
            end
        join
        repeat (2 * CPB) @(posedge clk_50M);
        #1;
        if ({frame_err, rx_valid, busy} !== 3'b101 || rx_data !== 8'hA5) begin
            $display("FAIL frame_err: got fe/valid/busy %b%b%b data %h want 101 a5", frame_err,
                     rx_valid, busy, rx_data);
            n_fail++;
        end
        n_tests++;
        uart_rxd = 1'b1;
        repeat (10) @(posedge clk_50M);
        #1;
        if (busy !== 1'b0) begin
            $display("FAIL break_exit: got busy %b want 0", busy);
            n_fail++;
        end
        n_tests++;
        pulse_read();
        if (frame_err !== 1'b0 || rx_data !== 8'hA5) begin
            $display("FAIL frame_clear: got fe %b data %h want 0 a5", frame_err, rx_data);
            n_fail++;
        end
        n_tests++;
        send_frame(8'h3C, 1'b1, 1'b0);
        if (rx_data !== 8'h3C || rx_valid !== 1'b1) begin
            $display("FAIL frame_next: got %h/%b want 3c/1", rx_data, rx_valid);
            n_fail++;
        end
        n_tests++;
        pulse_read();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        if ({rx_data, rx_valid, overrun} !== {8'h22, 2'b11}) begin
            $display("FAIL overrun_set: got %h/%b%b want 22/11", rx_data, rx_valid, overrun);
            n_fail++;
        end
        n_tests++;
        fork
            send_frame(8'h33, 1'b1, 1'b0);
            begin
                @(posedge clk_50M);
                repeat (STOP_CYC - 1) @(posedge clk_50M);
                #1 rx_read = 1'b1;
                @(posedge clk_50M); #1 rx_read = 1'b0;
            end
        join
        if ({rx_data, rx_valid, overrun} !== {8'h33, 2'b10}) begin
            $display("FAIL read_same_cycle: got %h/%b%b want 33/10", rx_data, rx_valid, overrun);
            n_fail++;
        end
        n_tests++;
        pulse_read();
        if (rx_valid !== 1'b0 || rx_data !== 8'h33) begin
            $display("FAIL overrun_read: got %b/%h want 0/33", rx_valid, rx_data);
            n_fail++;
        end
        n_tests++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b1);
        if ({rx_data, rx_valid, parity_err} !== {8'h07, 2'b11}) begin
            $display("FAIL parity_bad: got %h/%b%b want 07/11", rx_data, rx_valid, parity_err);
            n_fail++;
        end
        n_tests++;
        pulse_read();
        send_frame(8'h07, 1'b1, 1'b0);
        if ({rx_data, rx_valid, parity_err} !== {8'h07, 2'b10}) begin
            $display("FAIL parity_good: got %h/%b%b want 07/10", rx_data, rx_valid, parity_err);
            n_fail++;
        end
        n_tests++;
        pulse_read();
    endtask
`endif

    task automatic test_reset_midframe();
        send_frame(8'h5C, 1'b1, 1'b0);
        // Reset lands inside data bit 4; 0xF0 keeps the line high for the rest of the frame.
        fork
            send_frame(8'hF0, 1'b1, 1'b1);
            begin
                @(posedge clk_50M);
                repeat (85) @(posedge clk_50M);
                #1 reset = 1'b1;
                @(posedge clk_50M); #1 reset = 1'b0;
                if ({rx_data, rx_valid, busy} !== 10'h000) begin
                    $display("FAIL reset_mid: got %h/%b%b want 00/00", rx_data, rx_valid, busy);
                    n_fail++;
                end
                n_tests++;
            end
        join
        repeat (20) @(posedge clk_50M);
        #1;
        if ({rx_data, rx_valid, busy} !== 10'h000) begin
            $display("FAIL reset_nodeliver: got %h/%b%b want 00/00", rx_data, rx_valid, busy);
            n_fail++;
        end
        n_tests++;
        send_frame(8'h7E, 1'b1, 1'b0);
        if ({rx_data, rx_valid, overrun, frame_err} !== {8'h7E, 3'b100}) begin
            $display("FAIL reset_next: got %h/%b%b%b want 7e/100", rx_data, rx_valid, overrun, frame_err);
            n_fail++;
        end
        n_tests++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the HW1 transmitter.
- Deserialises the uart_rxd line into bytes, checks the stop bit, and holds each byte in a one-entry output register.
- Consumer handshake is read-to-clear: the consumer pulses rx_read to take the byte.
- Sits at the board pin, clocked from clk_50M, directly facing the uart_txd of a peer transmitter.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (5208), clocks per bit; integer division, truncated.

Ports:
- clk_50M  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- uart_rxd  in  1  asynchronous serial input; idle high.
- rx_read  in  1  one-cycle pulse; consumes rx_data and clears the status flags.
- rx_data  out  8  last good received byte, LSB received first.
- rx_valid  out  1  level; a byte is waiting to be read.
- overrun  out  1  sticky; an unread byte was overwritten.
- frame_err  out  1  sticky; a stop bit was sampled as 0.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: rx_data=8'h00, rx_valid=0, overrun=0, frame_err=0, busy=0, FSM=IDLE, counters=0. The 2-FF synchronizer also resets to 1.
- Reset asserted mid-frame aborts the frame; nothing is delivered.
- uart_rxd passes through a 2-FF synchronizer (rxd_s). All decisions use rxd_s.
- FSM states: IDLE, START, DATA, STOP, BREAK. A down-counter runs per bit and a 3-bit index counts data bits.
- IDLE:
  - On rxd_s==0, go to START with the counter loaded to CLKS_PER_BIT/2-1.
- START:
  - At counter 0, sample rxd_s.
  - If 0, go to DATA with counter=CLKS_PER_BIT-1 and index=0.
  - If 1, treat as a glitch and return to IDLE.
- DATA:
  - At each counter 0, shift rxd_s into the shift register LSB-first and reload the counter.
  - After index 7, go to STOP.
- STOP:
  - At counter 0, sample rxd_s.
  - If 1: load rx_data from the shift register, set rx_valid, and go to IDLE.
  - If 0: set frame_err, leave rx_data and rx_valid unchanged, and go to BREAK.
- BREAK:
  - Wait until rxd_s==1, then go to IDLE. This prevents re-triggering on a held-low line.
- Latency: the stop sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after the cycle IDLE sees rxd_s==0. rx_valid rises on the next clock edge.
- rx_read with rx_valid=1: clears rx_valid, overrun and frame_err on the next edge. rx_data is held.
- rx_read with rx_valid=0: clears overrun and frame_err only.
- Good byte completes while rx_valid=1 and no rx_read in the same cycle: rx_data is overwritten, rx_valid stays 1, overrun is set.
- Completion and rx_read in the same cycle: the new byte is loaded, rx_valid stays 1, overrun is not set, and frame_err is cleared.
- Framing error and rx_read in the same cycle: frame_err ends at 1, because the set wins.
- Back-to-back frames: a start bit directly after the stop sample is accepted. The receiver returns to IDLE with half a bit period of margin.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP. It samples a 9th bit one CLKS_PER_BIT after the last data bit.
  - New parameter PARITY_ODD, default 0 (even parity).
  - New output parity_err (1 bit, sticky, reset 0, cleared by rx_read).
  - On a parity mismatch with a good stop bit: the byte is still loaded and rx_valid is set, and parity_err is set.
  - Stop-bit latency grows by CLKS_PER_BIT.
- When undefined:
  - The frame is 8N1 exactly, and the parity_err port does not exist.

Test Plan:
- Reset then idle line: after reset, hold uart_rxd=1 for 1 ms -> all outputs stay 0 and busy stays 0.
- Basic receive: send 0x21, 0x43, 0x65 at 104160 ns/bit, pulsing rx_read after each -> rx_data matches each byte, rx_valid rises once per byte, overrun=0, frame_err=0.
- Glitch rejection: drive uart_rxd low for 1 us -> FSM returns to IDLE, no rx_valid. A following 0xA5 is received correctly.
- Framing error: send 0x5A with stop=0, then the line held low for 2 bit periods, then high -> frame_err=1, rx_valid=0, rx_data unchanged. A subsequent 0x3C is received with rx_valid=1.
- Overrun and simultaneous read: send 0x11 then 0x22 with no read -> rx_data=0x22, overrun=1. Then send 0x33 with rx_read pulsed on the stop-sample cycle -> rx_data=0x33, rx_valid=1, overrun=0.
- Reset mid-frame and parity: assert reset during data bit 4 -> no byte delivered, and the next frame 0x7E is received cleanly. With UART_RX_PARITY_EN defined, send 0x07 with even parity bit=0 -> parity_err=1 and rx_data=0x07.
